// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter and instruction-fetch front end.
// Fetches one instruction at a time over a simple req/ack memory port,
// presents it to decode with a valid/ready handshake, and computes the
// next pc from the decoded control signals when decode accepts it.
// Optional feature macro: PC_FETCH_PERF_CNT_EN adds an accepted-instruction
// counter on fetch_count. Without it, fetch_count is tied to zero.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 14
) (
    input  logic               clock,
    input  logic               reset,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        Instruction,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               Branch,
    input  logic               nBranch,
    input  logic               Jmp,
    input  logic               Jal,
    input  logic               Jr,
    input  logic               Zero,
    input  logic [31:0]        Addr_result,
    input  logic [31:0]        Read_data_1,
    output logic [31:0]        pc,
    output logic [31:0]        branch_base_addr,
    output logic [31:0]        link_addr,
    output logic [31:0]        fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] link_q, link_d;
    logic [31:0] next_pc;
    logic        accept;
    logic        take_branch;

    // The two low bits of the jump/branch sources are dropped by design.
    logic unused_low_bits;
    assign unused_low_bits = ^{Read_data_1[1:0], Addr_result[1:0]};

    assign imem_req         = (state_q == S_REQ);
    assign instr_valid      = (state_q == S_HOLD);
    assign accept           = instr_valid && instr_ready;
    assign imem_addr        = pc_q[IMEM_AW+1:2];
    assign pc               = pc_q;
    assign Instruction      = instr_q;
    assign link_addr        = link_q;
    assign branch_base_addr = pc_q + 32'd4;
    assign take_branch      = (Branch && Zero) || (nBranch && !Zero);

    // Next-pc select: jr beats j/jal beats conditional branch beats pc+4.
    always_comb begin
        next_pc = branch_base_addr;
        if (Jr)
            next_pc = {Read_data_1[31:2], 2'b00};
        else if (Jmp || Jal)
            next_pc = {branch_base_addr[31:28], instr_q[25:0], 2'b00};
        else if (take_branch)
            next_pc = {Addr_result[31:2], 2'b00};
    end

    // FSM next state plus datapath updates; controls only matter on accept.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        link_d  = link_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    pc_d    = next_pc;
                    state_d = S_REQ;
                    if (Jal)
                        link_d = branch_base_addr;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any fetch in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= {RESET_PC[31:2], 2'b00};
            instr_q <= 32'h0;
            link_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            link_q  <= link_d;
        end
    end

`ifdef PC_FETCH_PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    assign cnt_d       = cnt_q + {31'd0, accept};
    assign fetch_count = cnt_q;

    // Accepted-instruction counter, wraps naturally at 32 bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt_q <= 32'h0;
        else
            cnt_q <= cnt_d;
    end
`else
    assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed bench for pc_fetch_unit. A driver plays the
// instruction memory and the decode stage; each fetched word and its pc go
// into a queue that a negedge monitor pops whenever instr_valid rises.
module tb_pc_fetch_unit;
    localparam int AW = 14;

    logic          clock, reset;
    logic [AW-1:0] imem_addr;
    logic          imem_req, imem_ack;
    logic [31:0]   imem_rdata, Instruction;
    logic          instr_valid, instr_ready;
    logic          Branch, nBranch, Jmp, Jal, Jr, Zero;
    logic [31:0]   Addr_result, Read_data_1;
    logic [31:0]   pc, branch_base_addr, link_addr, fetch_count;

    int            checks = 0;
    int            failures = 0;
    int            exp_cnt = 0;
    logic [63:0]   exp_q[$];
    logic          vprev = 1'b0;

    pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(AW)) dut (
        .clock(clock), .reset(reset),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .Instruction(Instruction), .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jr(Jr),
        .Zero(Zero), .Addr_result(Addr_result), .Read_data_1(Read_data_1),
        .pc(pc), .branch_base_addr(branch_base_addr),
        .link_addr(link_addr), .fetch_count(fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_fc();
`ifdef PC_FETCH_PERF_CNT_EN
        return exp_cnt;
`else
        return 32'h0;
`endif
    endfunction

    // Monitor: every new valid instruction must match the oldest expectation.
    always @(negedge clock) begin
        logic [63:0] e;
        if (instr_valid && !vprev) begin
            if (exp_q.size() == 0) begin
                chk("mon_unexpected_valid", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("mon_instr", Instruction, e[63:32]);
                chk("mon_pc", pc, e[31:0]);
            end
        end
        vprev = instr_valid;
    end

    task automatic randomize_ctrl();
        Branch      = 1'($urandom_range(0, 1));
        nBranch     = 1'($urandom_range(0, 1));
        Jmp         = 1'($urandom_range(0, 1));
        Jal         = 1'($urandom_range(0, 1));
        Jr          = 1'($urandom_range(0, 1));
        Zero        = 1'($urandom_range(0, 1));
        Addr_result = $urandom;
        Read_data_1 = $urandom;
    endtask

    // Memory side: wait for a request, answer one cycle later.
    task automatic fetch(input logic [31:0] epc, input logic [31:0] w);
        int n = 0;
        logic [31:0] ea;
        ea = {18'd0, epc[AW+1:2]};
        @(negedge clock);
        while (!imem_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!imem_req) begin
            chk("fetch_req_timeout", 32'h0, 32'h1);
            return;
        end
        chk("fetch_addr", {18'd0, imem_addr}, ea);
        exp_q.push_back({w, epc});
        @(posedge clock); #1;
        imem_ack   = 1'b1;
        imem_rdata = w;
        chk("fetch_addr_stable", {18'd0, imem_addr}, ea);
        chk("fetch_valid_early", {31'd0, instr_valid}, 32'h0);
        @(posedge clock); #1;
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("fetch_valid_latency", {31'd0, instr_valid}, 32'h1);
        chk("fetch_req_drop", {31'd0, imem_req}, 32'h0);
    endtask

    // Decode side: accept the held instruction with the given controls.
    task automatic accept(input logic br, input logic nbr, input logic jmp,
                          input logic jal, input logic jr, input logic zero,
                          input logic [31:0] ar, input logic [31:0] rd1,
                          input logic [31:0] exp_pc);
        int n = 0;
        while (!instr_valid && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (!instr_valid) begin
            chk("accept_valid_timeout", 32'h0, 32'h1);
            return;
        end
        Branch = br; nBranch = nbr; Jmp = jmp; Jal = jal; Jr = jr; Zero = zero;
        Addr_result = ar; Read_data_1 = rd1;
        instr_ready = 1'b1;
        @(posedge clock); #1;
        instr_ready = 1'b0;
        randomize_ctrl();
        exp_cnt++;
        chk("accept_pc", pc, exp_pc);
        chk("accept_req_again", {31'd0, imem_req}, 32'h1);
        chk("accept_valid_drop", {31'd0, instr_valid}, 32'h0);
        chk("accept_fetch_count", fetch_count, exp_fc());
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
        randomize_ctrl();
        repeat (2) @(negedge clock);
        chk("rst_req", {31'd0, imem_req}, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_link", link_addr, 32'h0);
        chk("rst_fetch_count", fetch_count, 32'h0);
        reset = 1'b0;

        // j 0x40
        fetch(32'h0000_0000, 32'h0800_0010);
        accept(0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0040);
        // plain sequential
        fetch(32'h0000_0040, 32'h0000_0000);
        accept(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0044);
        // beq taken, beq not taken, bne taken
        fetch(32'h0000_0044, 32'h1000_0001);
        accept(1, 0, 0, 0, 0, 1, 32'h100, 32'h0, 32'h0000_0100);
        fetch(32'h0000_0100, 32'h1000_0002);
        accept(1, 0, 0, 0, 0, 0, 32'h100, 32'h0, 32'h0000_0104);
        fetch(32'h0000_0104, 32'h1400_0003);
        accept(0, 1, 0, 0, 0, 0, 32'h100, 32'h0, 32'h0000_0100);
        // jr to 0x0040_0010
        fetch(32'h0000_0100, 32'h0000_0008);
        accept(0, 0, 0, 0, 1, 0, 32'h0, 32'h0040_0010, 32'h0040_0010);
        // jal
        fetch(32'h0040_0010, 32'h0C00_0020);
        accept(0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0000_0080);
        chk("jal_link", link_addr, 32'h0040_0014);
        // jr and j together: jr wins, low bits dropped
        fetch(32'h0000_0080, 32'h0800_0100);
        accept(0, 0, 1, 0, 1, 0, 32'h0, 32'h0000_0203, 32'h0000_0200);
        chk("link_hold", link_addr, 32'h0040_0014);

        // stall for 5 cycles with a spurious ack in the middle
        fetch(32'h0000_0200, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            imem_ack   = (i == 2);
            imem_rdata = 32'h1234_5678;
            randomize_ctrl();
            @(posedge clock); #1;
            chk("hold_instr", Instruction, 32'hDEAD_BEEF);
            chk("hold_pc", pc, 32'h0000_0200);
            chk("hold_valid", {31'd0, instr_valid}, 32'h1);
        end
        imem_ack = 1'b0;
        accept(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0204);

        // wrap at the top of the address space
        fetch(32'h0000_0204, 32'h0000_0011);
        accept(0, 0, 0, 0, 1, 0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 32'h0000_0022);
        chk("wrap_bba", branch_base_addr, 32'h0000_0000);
        accept(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0000);

        // reset while in REQ, with a late ack straddling the release
        reset = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        exp_cnt = 0;
        @(negedge clock);
        chk("rreq_req", {31'd0, imem_req}, 32'h0);
        chk("rreq_valid", {31'd0, instr_valid}, 32'h0);
        chk("rreq_pc", pc, 32'h0);
        chk("rreq_link", link_addr, 32'h0);
        chk("rreq_fetch_count", fetch_count, 32'h0);
        reset = 1'b0;
        @(posedge clock); #1;
        imem_ack = 1'b0;
        chk("late_ack_req", {31'd0, imem_req}, 32'h1);
        @(negedge clock);
        chk("late_ack_valid", {31'd0, instr_valid}, 32'h0);
        chk("late_ack_instr", Instruction, 32'h0);
        fetch(32'h0000_0000, 32'h0000_0033);
        accept(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0004);

        repeat (2) @(negedge clock);
        chk("queue_drain", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter IMEM_AW, default 14: instruction-memory word-address width.
REQ-003 The block SHALL have one clock and an asynchronous active-high reset, with these ports:
- clock  input  1  sole clock; all state on the rising edge.
- reset  input  1  asynchronous, active-high.
- imem_addr  output  IMEM_AW  word address, equal to PC[IMEM_AW+1:2].
- imem_req  output  1  fetch request to instruction memory.
- imem_ack  input  1  one-cycle pulse: imem_rdata valid.
- imem_rdata  input  32  fetched instruction word.
- Instruction  output  32  registered instruction presented to decode/control.
- instr_valid  output  1  Instruction is valid.
- instr_ready  input  1  downstream has consumed the instruction and next-PC inputs are valid.
- Branch, nBranch, Jmp, Jal, Jr  input  1 each  decoded control for the current Instruction.
- Zero  input  1  ALU zero flag.
- Addr_result  input  32  branch target from the execute stage.
- Read_data_1  input  32  rs value, used as the jr target.
- pc  output  32  address of the current Instruction.
- branch_base_addr  output  32  pc+4, combinational.
- link_addr  output  32  return address latched by jal.
- fetch_count  output  32  count of accepted instructions.

Function
REQ-004 The FSM SHALL have three states, IDLE, REQ and HOLD, with these transitions:
- IDLE -> REQ unconditionally, one cycle after reset release.
- REQ -> HOLD on imem_ack.
- HOLD -> REQ on instr_valid && instr_ready.
REQ-005 imem_req SHALL be 1 exactly in REQ, and imem_addr SHALL be stable throughout REQ.
REQ-006 On imem_ack in REQ, Instruction SHALL load imem_rdata and instr_valid SHALL rise on the next cycle (fetch latency: ack + 1 cycle).
REQ-007 imem_ack outside REQ SHALL be ignored, with no state, Instruction or pc change.
REQ-008 instr_valid SHALL be 1 exactly in HOLD, and Instruction and pc SHALL hold steady while instr_ready is 0.
REQ-009 An accept SHALL be the cycle in which instr_valid && instr_ready; on accept, pc SHALL load next_pc, selected by priority:
- (1) Jr: {Read_data_1[31:2], 2'b00}.
- (2) Jmp or Jal: {branch_base_addr[31:28], Instruction[25:0], 2'b00}.
- (3) (Branch && Zero) || (nBranch && !Zero): {Addr_result[31:2], 2'b00}.
- (4) otherwise: branch_base_addr.
REQ-010 If multiple selects are asserted together, the priority in REQ-009 SHALL decide, with no error flag raised.
REQ-011 pc[1:0] SHALL always be 2'b00.
REQ-012 Arithmetic SHALL be 32-bit modulo: pc 32'hFFFF_FFFC +4 wraps to 32'h0.
REQ-013 link_addr SHALL load branch_base_addr only on an accept with Jal=1, and SHALL hold otherwise.
REQ-014 Control inputs SHALL be sampled only on the accept cycle, and are don't-care otherwise.
REQ-015 branch_base_addr SHALL equal pc + 32'd4 combinationally.

Reset
REQ-016 While reset=1, asynchronously:
- state = IDLE; imem_req = 0; instr_valid = 0.
- pc = RESET_PC; Instruction = 32'h0.
- link_addr = 32'h0; fetch_count = 32'h0.
REQ-017 A reset asserted during REQ or HOLD SHALL abandon the fetch, and a late imem_ack after reset release SHALL be ignored per REQ-007.

Configuration
REQ-018 Macro PC_FETCH_PERF_CNT_EN SHALL control the fetch counter:
- Defined: fetch_count increments by 1 on every accept and wraps 32'hFFFF_FFFF -> 0.
- Undefined: fetch_count is constant 32'h0 and no counter register is synthesised.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset release, imem_ack one cycle after imem_req -> imem_addr=0, instr_valid rises 2 cycles after REQ entry, pc=0.
- Accept with no control, pc=32'h40 -> pc=32'h44, imem_req reasserts the next cycle.
- Branch=1, Zero=1, Addr_result=32'h100 -> pc=32'h100; same with Zero=0 -> pc+4; nBranch=1, Zero=0 -> pc=32'h100.
- Jal=1, pc=32'h0040_0010, Instruction[25:0]=26'h0000020 -> pc=32'h0000_0080, link_addr=32'h0040_0014.
- Jr=1 and Jmp=1 together, Read_data_1=32'h0000_0203 -> pc=32'h0000_0200.
- instr_ready held 0 for 5 cycles with a spurious imem_ack -> Instruction and pc unchanged; reset pulsed in REQ -> state IDLE, pc=RESET_PC, and (with PC_FETCH_PERF_CNT_EN) fetch_count=0.
